// File: rtl/snake_pkg.sv
// Shared definitions for the snake playfield blocks: FSM encoding, default
// geometry and the 16-bit Galois LFSR step.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GET  = 3'd1,
    ST_SCAN = 3'd2,
    ST_DONE = 3'd3,
    ST_FAIL = 3'd4
  } state_e;

  localparam int DEF_XSIZE   = 48;
  localparam int DEF_YSIZE   = 64;
  localparam int DEF_COORD_W = 6;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/item_pos_gen_multi_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances on every clock after reset.
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  output logic [15:0] o_Lfsr
);

  logic [15:0] lfsr_q;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_step(lfsr_q);
  end

  assign o_Lfsr = lfsr_q;

endmodule

// File: rtl/item_pos_gen_multi.sv
// Multi-slot item placer: draws LFSR candidates, rejects those on other items
// or on the snake body (scanned one segment per cycle), with bounded retries.
module item_pos_gen_multi
  import snake_pkg::*;
#(
  parameter int          XSIZE     = DEF_XSIZE,
  parameter int          YSIZE     = DEF_YSIZE,
  parameter int          COORD_W   = DEF_COORD_W,
  parameter int          MAX_SIZE  = 64,
  parameter int          N_ITEMS   = 4,
  parameter int          MAX_RETRY = 15,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         SIZE_W    = $clog2(MAX_SIZE + 1),
  localparam int         IDX_W     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic [MAX_SIZE*COORD_W-1:0]  i_Body_x,
  input  logic [MAX_SIZE*COORD_W-1:0]  i_Body_y,
  input  logic [SIZE_W-1:0]            i_Body_size,
  input  logic                         i_Req,
  input  logic                         i_Clr,
  input  logic [IDX_W-1:0]             i_Idx,
  output logic [N_ITEMS*COORD_W-1:0]   o_Item_x,
  output logic [N_ITEMS*COORD_W-1:0]   o_Item_y,
  output logic [N_ITEMS-1:0]           o_Item_valid,
  output logic                         o_Busy,
  output logic                         o_Done,
  output logic                         o_Fail
);

  localparam int K_W  = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CW1  = COORD_W + 1;
  localparam logic [CW1-1:0]    XS   = CW1'(XSIZE);
  localparam logic [CW1-1:0]    YS   = CW1'(YSIZE);
  localparam logic [SIZE_W-1:0] MAXS = SIZE_W'(MAX_SIZE);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           tgt_q, tgt_d;
  logic [RT_W-1:0]            retry_q, retry_d;
  logic [K_W-1:0]             k_q, k_d;
  logic [COORD_W-1:0]         cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [N_ITEMS*COORD_W-1:0] item_x_q, item_x_d, item_y_q, item_y_d;
  logic [N_ITEMS-1:0]         valid_q, valid_d;

  logic [15:0]        lfsr;
  logic [CW1-1:0]     rx, ry, cx, cy;
  logic [SIZE_W-1:0]  size_c;
  logic [COORD_W-1:0] seg_x, seg_y;
  logic               item_hit, seg_hit, last_seg, reject;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .o_Lfsr (lfsr)
  );

  // A single subtraction folds the 7-bit draw; anything still out of range is rejected
  assign rx = lfsr[COORD_W:0];
  assign ry = lfsr[2*COORD_W+1:COORD_W+1];
  assign cx = (rx >= XS) ? rx - XS : rx;
  assign cy = (ry >= YS) ? ry - YS : ry;

  assign size_c   = (i_Body_size > MAXS) ? MAXS : i_Body_size;
  assign seg_x    = i_Body_x[k_q*COORD_W +: COORD_W];
  assign seg_y    = i_Body_y[k_q*COORD_W +: COORD_W];
  assign seg_hit  = (seg_x == cand_x_q) && (seg_y == cand_y_q);
  assign last_seg = (SIZE_W'(k_q) == size_c - SIZE_W'(1));

  always_comb begin
    item_hit = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (valid_q[i] && (IDX_W'(i) != tgt_q) &&
          (item_x_q[i*COORD_W +: COORD_W] == cx[COORD_W-1:0]) &&
          (item_y_q[i*COORD_W +: COORD_W] == cy[COORD_W-1:0]))
        item_hit = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    retry_d  = retry_q;
    k_d      = k_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    item_x_d = item_x_q;
    item_y_d = item_y_q;
    valid_d  = valid_q;
    reject   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Req) begin
          tgt_d   = i_Idx;
          retry_d = '0;
          state_d = ST_GET;
        end else if (i_Clr) begin
          valid_d[i_Idx] = 1'b0;
        end
      end
      ST_GET: begin
        cand_x_d = cx[COORD_W-1:0];
        cand_y_d = cy[COORD_W-1:0];
        k_d      = '0;
        if ((cx >= XS) || (cy >= YS) || item_hit) reject = 1'b1;
        else                                      state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (size_c == '0)  state_d = ST_DONE;
        else if (seg_hit)  reject  = 1'b1;
        else if (last_seg) state_d = ST_DONE;
        else               k_d     = k_q + K_W'(1);
      end
      ST_DONE: begin
        item_x_d[tgt_q*COORD_W +: COORD_W] = cand_x_q;
        item_y_d[tgt_q*COORD_W +: COORD_W] = cand_y_q;
        valid_d[tgt_q] = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (reject) begin
      if (retry_q == RT_W'(MAX_RETRY)) begin
        state_d = ST_FAIL;
      end else begin
        retry_d = retry_q + RT_W'(1);
        state_d = ST_GET;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q  <= ST_IDLE;
      tgt_q    <= '0;
      retry_q  <= '0;
      k_q      <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      item_x_q <= '0;
      item_y_q <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      retry_q  <= retry_d;
      k_q      <= k_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      item_x_q <= item_x_d;
      item_y_q <= item_y_d;
      valid_q  <= valid_d;
    end
  end

  assign o_Item_x     = item_x_q;
  assign o_Item_y     = item_y_q;
  assign o_Item_valid = valid_q;
  assign o_Busy       = (state_q != ST_IDLE);
  assign o_Done       = (state_q == ST_DONE);
  assign o_Fail       = (state_q == ST_FAIL);

endmodule

// File: doc/item_pos_gen_multi.md
Name: item_pos_gen_multi

Overview:
- Successor item placer for the snake playfield. Maintains N_ITEMS independent item slots.
- On request, places a random item in one slot that overlaps neither a snake body segment nor another valid item.
- Scans the body sequentially, one segment per cycle, so MAX_SIZE scales without a wide compare tree.
- Bounded retry with explicit failure reporting. Sits between the game-logic FSM and the renderer.

Parameters:
- XSIZE, 48: playfield columns; 1 ≤ XSIZE ≤ 2^COORD_W.
- YSIZE, 64: playfield rows; 1 ≤ YSIZE ≤ 2^COORD_W.
- COORD_W, 6: coordinate width; 2*(COORD_W+1) ≤ 16.
- MAX_SIZE, 64: maximum body segments.
- N_ITEMS, 4: number of item slots.
- MAX_RETRY, 15: rejected candidates allowed before failure.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- i_Clk  in  1  clock; reset i_Rst, asynchronous, active-low; clock i_Clk.
- i_Rst  in  1  async active-low reset.
- i_Body_x  in  MAX_SIZE*COORD_W  packed segment x; segment k at [k*COORD_W +: COORD_W].
- i_Body_y  in  MAX_SIZE*COORD_W  packed segment y.
- i_Body_size  in  $clog2(MAX_SIZE+1)  valid segment count; values > MAX_SIZE are clamped to MAX_SIZE.
- i_Req  in  1  place an item in slot i_Idx.
- i_Clr  in  1  invalidate slot i_Idx (item eaten).
- i_Idx  in  $clog2(N_ITEMS) (min 1)  slot select.
- o_Item_x  out  N_ITEMS*COORD_W  per-slot x.
- o_Item_y  out  N_ITEMS*COORD_W  per-slot y.
- o_Item_valid  out  N_ITEMS  per-slot valid.
- o_Busy  out  1  high in every non-IDLE state.
- o_Done  out  1  one-cycle pulse: placement succeeded.
- o_Fail  out  1  one-cycle pulse: retries exhausted.

Behaviour:
- Reset: state IDLE; all o_Item_x/y = 0; o_Item_valid = 0; o_Busy, o_Done, o_Fail = 0; retry count = 0; LFSR = SEED.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Free-running: advances every cycle, including while IDLE.
  - rx = lfsr[COORD_W:0]; ry = lfsr[2*COORD_W+1:COORD_W+1].
- Fold: cx = (rx ≥ XSIZE) ? rx−XSIZE : rx; likewise cy with YSIZE. If cx ≥ XSIZE or cy ≥ YSIZE after the fold, the candidate is rejected.
- States: IDLE, GET, SCAN, DONE, FAIL.
- IDLE:
  - i_Clr → clear o_Item_valid[i_Idx] next edge.
  - i_Req → latch i_Idx as tgt, retry = 0, go to GET.
  - i_Req and i_Clr together: i_Req wins and the slot is re-placed.
- GET (1 cycle):
  - Latch candidate (cx, cy) and k = 0.
  - Reject if out of range, or if it equals any valid slot ≠ tgt. The item compare is combinational over N_ITEMS.
  - If not rejected, go to SCAN.
- Reject rule: if retry == MAX_RETRY go to FAIL, else retry+1 and stay in GET.
- SCAN:
  - Each cycle compares candidate against segment k.
  - Hit → apply reject rule and go to GET or FAIL.
  - No hit and k == clamped_size−1 → DONE; otherwise k+1.
  - Clamped size 0 → SCAN lasts 1 cycle with no compare, then DONE.
- DONE (1 cycle): write the candidate into slot tgt, set valid[tgt], pulse o_Done, go to IDLE. The new value is visible on the cycle after o_Done.
- FAIL (1 cycle): pulse o_Fail, go to IDLE. Slot tgt is unchanged, including its valid bit.
- Latency on first-try success = 1 (GET) + max(1, size) (SCAN) + 1 (DONE) cycles after the i_Req edge.
- While o_Busy: i_Req and i_Clr are ignored, not queued. The caller holds i_Body_* and i_Body_size stable; behaviour is undefined otherwise.
- Reset mid-operation returns everything to reset values immediately; no pulse is emitted.
- Comparisons are full COORD_W-bit equality on both axes.

Decomposition:
- Package snake_pkg: state encoding (IDLE=0, GET=1, SCAN=2, DONE=3, FAIL=4; 3 bits), default XSIZE/YSIZE/COORD_W, LFSR polynomial constant.
- Sub-module lfsr16 (i_Clk, i_Rst, parameter SEED, 16-bit output), replacing the old LFSR instance.
- Slot storage and FSM stay in the top module.

Test Plan:
1. Reset with SEED=16'hACE1 → all outputs 0. Release reset; i_Req idx=2 with size 0 → o_Done exactly 3 cycles later; slot 2 equals the reference-model LFSR value folded; valid = 4'b0100.
2. Body size 5 with segments at the model-predicted first candidate, i_Req idx=0 → first candidate rejected; o_Done at the next clean candidate; item never on any segment; cycle count matches the model.
3. XSIZE=YSIZE=2, body covers (0,0),(0,1),(1,0),(1,1), MAX_RETRY=3 → o_Fail after exactly 4 rejects; o_Done never asserted; valid unchanged.
4. Slots 0–2 valid, i_Req idx=3, 500 iterations with random bodies → placed item never equals slots 0–2 or any body segment; x < 48, y < 64.
5. i_Req again while busy, and i_Clr while busy → ignored. i_Clr idx=1 in IDLE → valid[1]=0 next cycle. i_Req and i_Clr same cycle on idx 1 → slot re-placed.
6. Assert i_Rst mid-SCAN → o_Busy=0, all slots invalid, no o_Done/o_Fail pulse. The next i_Req works normally.
